// File: rtl/mem_write_buffer.sv
// Posted-write buffer between a cache controller and memory: writes are queued and drained in order,
// reads hit the queue (youngest match) or wait for the queue to drain before going to memory.
module mem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_rw,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    output logic                     req_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_ready,
    output logic                     mem_valid,
    output logic                     mem_rw,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_DRAIN = 2'd1;
    localparam logic [1:0] RD_REQ   = 2'd2;
    localparam logic [1:0] RD_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   rd_addr_q, rd_addr_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_ready_q, resp_ready_d;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          accept, push, pop, drain_act;
    logic          hit;
    logic [31:0]   hit_data;
    logic [AW-1:0] idx;

    // Byte offset within a word never matters: queue and memory are word-addressed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign req_ready  = (state_q == IDLE) && !full;
    assign resp_data  = resp_data_q;
    assign resp_ready = resp_ready_q;

    assign accept    = req_valid && req_ready;
    assign push      = accept && req_rw;
    assign drain_act = ((state_q == IDLE) || (state_q == RD_DRAIN)) && !empty;
    assign pop       = drain_act && mem_gnt;

    always_comb begin
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain_act) begin
            mem_valid = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = {addr_q[rd_ptr_q], 2'b00};
            mem_wdata = data_q[rd_ptr_q];
        end else if (state_q == RD_REQ) begin
            mem_valid = 1'b1;
            mem_addr  = {rd_addr_q, 2'b00};
        end
    end

    // Walk from head (oldest) to tail so the last match found is the youngest write.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == req_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        resp_data_d  = resp_data_q;
        resp_ready_d = 1'b0;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_rw) begin
                        resp_ready_d = 1'b1;
                    end else if (hit) begin
                        resp_data_d  = hit_data;
                        resp_ready_d = 1'b1;
                    end else begin
                        rd_addr_d = req_addr[31:2];
                        state_d   = empty ? RD_REQ : RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (empty) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem_gnt) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (mem_rvalid) begin
                    resp_data_d  = mem_rdata;
                    resp_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_addr_q    <= '0;
            resp_data_q  <= '0;
            resp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_addr_q    <= rd_addr_d;
            resp_data_q  <= resp_data_d;
            resp_ready_q <= resp_ready_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= req_addr[31:2];
            data_q[wr_ptr_q] <= req_data;
        end
    end

endmodule
